cu_ctrl: RTL and testbench
==========================

# cu_ctrl

Control-signal generator paired with the `CU_counter` sequencer in the Simple CPU. It consumes the counter's state value `q`, decodes it into datapath micro-operations, and drives the counter's `load`/`inc`/`clr` inputs back, closing the control loop. It adds a run/halt/fault state machine, memory-wait handling with timeout, and a retired-instruction counter.

## Interface
- `N`, 4: width of `q` (must match the counter's `N`).
- `MEM_TIMEOUT`, 15: maximum consecutive stall cycles in a memory state before fault; valid range 1..2^`WAIT_W`-1.
- `WAIT_W`, 4: width of the stall counter.
- `RET_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `q` in N: current counter state.
- `start` in 1: level/pulse; leaves IDLE or HALT.
- `halt_req` in 1: request to stop at the next instruction boundary.
- `mem_ready` in 1: memory read data valid this cycle.
- `cnt_load`, `cnt_inc`, `cnt_clr` out 1 each: to counter `load`/`inc`/`clr`.
- `ar_from_pc`, `ar_from_dr`, `pc_inc`, `pc_load`, `dr_load`, `ir_load`, `ac_add`, `ac_and`, `ac_inc` out 1 each: datapath micro-ops.
- `mem_rd` out 1: memory read strobe.
- `instr_done` out 1: high in the final execute cycle of each instruction.
- `running`, `halted`, `fault` out 1 each: FSM status.
- `retired` out RET_W: instructions completed.

## Operation
- FSM states: IDLE, RUN, HALT, FAULT. Reset enters IDLE.
- IDLE/HALT: `cnt_clr`=1, all micro-ops 0. `start`=1 moves to RUN at the next edge. `halt_req` is ignored.
- RUN: outputs are combinational in `q` and `mem_ready`:
  - q=0 FETCH1: `ar_from_pc`, `cnt_inc`.
  - q=1 FETCH2 (mem): `mem_rd`. If `mem_ready`=1: `dr_load`, `pc_inc`, `cnt_inc`.
  - q=2 FETCH3: `ir_load`, `ar_from_dr`, `cnt_load`.
  - q=3 ADD1 (mem): `mem_rd`. If `mem_ready`=1: `dr_load`, `cnt_inc`.
  - q=4 ADD2: `ac_add`, `cnt_clr`, `instr_done`.
  - q=5 AND1 (mem): same as ADD1.
  - q=6 AND2: `ac_and`, `cnt_clr`, `instr_done`.
  - q=7 JMP1: `pc_load`, `cnt_clr`, `instr_done`.
  - q=8 INC1: `ac_inc`, `cnt_clr`, `instr_done`.
  - q>=9: illegal. All outputs 0 except `cnt_clr`=1; FSM moves to FAULT.
- Stall handling: in a memory state with `mem_ready`=0, all counter controls are 0, so the counter holds. The stall counter increments each such cycle. It clears on `mem_ready`=1 or on leaving a memory state. If the counter is at `MEM_TIMEOUT`-1 and `mem_ready`=0, the FSM moves to FAULT.
- `mem_ready` is ignored outside memory states.
- Halt: `halt_req` in RUN sets `halt_pending`. When `instr_done`=1 and `halt_pending` is set (including a `halt_req` arriving in that same cycle), the FSM moves to HALT at that edge and `halt_pending` clears.
- `start` in RUN is ignored.
- FAULT: `cnt_clr`=1, `fault`=1, all micro-ops 0. Only `rst_n` exits FAULT.
- `retired` increments at each edge where `instr_done`=1 and wraps modulo 2^RET_W. It holds in IDLE, HALT and FAULT.
- Exactly one of `cnt_load`, `cnt_inc`, `cnt_clr` is high in any cycle, or none during a stall.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `halt_pending`=0, stall counter 0, `retired`=0.
  - Outputs after reset: `cnt_clr`=1, `running`=0, `halted`=0, `fault`=0, `instr_done`=0, all micro-ops and `mem_rd` 0.
  - `rst_n` low mid-instruction aborts immediately. No `instr_done` and no `retired` update occur on the reset edge.
- Status outputs are registered: `running`=RUN, `halted`=HALT, `fault`=FAULT.
- `start` in IDLE: the counter has been held at q=0, so FETCH1 executes in the first RUN cycle.
- Zero-wait instruction latency:
  - ADD and AND: 5 cycles.
  - JMP and INC: 4 cycles.
  - Each stall cycle adds 1.
- Back-to-back instructions have no bubble: q returns to 0 on the edge after the `cnt_clr` cycle.

## Test plan
- Reset then `start`=1 for one cycle, with q driven by an attached counter, opcode 00, `mem_ready`=1: micro-op sequence FETCH1, FETCH2, FETCH3, ADD1, ADD2; `instr_done` high on cycle 5 only; `retired`=1.
- INC instruction followed by JMP instruction, zero wait: 4+4 cycles; `ac_inc` then `pc_load`; `retired`=2; no idle cycle between them.
- FETCH2 with `mem_ready` low for 3 cycles: q holds at 1 with `mem_rd`=1 and no counter controls for 3 cycles; on the 4th cycle `dr_load`+`pc_inc`+`cnt_inc`; total ADD latency 8.
- ADD1 with `mem_ready` held low and `MEM_TIMEOUT`=15: after 15 stall cycles `fault`=1, `cnt_clr`=1; `start` has no effect; `rst_n`=0 returns to IDLE.
- `halt_req` pulsed during FETCH2 of an AND: instruction completes, `halted`=1 the next cycle, counter held at q=0. `start` resumes with FETCH1; `retired` keeps its count across the halt.
- q forced to 12 in RUN: `cnt_clr`=1 that cycle and `fault`=1 the next; `retired` unchanged.

Source files
------------

// File: rtl/cu_ctrl.sv
// -----------------------------------------------------------------------------
// cu_ctrl - control-signal generator for the Simple CPU sequencer.
//
// Decodes the sequencer state q into datapath micro-ops and drives the
// counter's load/inc/clr back. It also provides a run/halt/fault FSM, a
// memory-wait stall counter with timeout, and a retired-instruction counter.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   q                 : current sequencer state
//   start             : leave IDLE/HALT and begin fetching
//   halt_req          : stop at the next instruction boundary
//   mem_ready         : memory read data valid this cycle
//   cnt_load/inc/clr  : sequencer controls
//   ar_from_pc .. ac_inc, mem_rd : datapath micro-ops / memory strobe
//   instr_done        : final execute cycle of an instruction
//   running/halted/fault : registered FSM status
//   retired           : count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module cu_ctrl #(
   parameter int N           = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = 4,
   parameter int RET_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     q,
   input  logic             start,
   input  logic             halt_req,
   input  logic             mem_ready,
   output logic             cnt_load,
   output logic             cnt_inc,
   output logic             cnt_clr,
   output logic             ar_from_pc,
   output logic             ar_from_dr,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             dr_load,
   output logic             ir_load,
   output logic             ac_add,
   output logic             ac_and,
   output logic             ac_inc,
   output logic             mem_rd,
   output logic             instr_done,
   output logic             running,
   output logic             halted,
   output logic             fault,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_e;

   state_e            state_q, state_d;
   logic              halt_pend_q, halt_pend_d;
   logic [WAIT_W-1:0] stall_q, stall_d;
   logic [RET_W-1:0]  ret_q, ret_d;
   logic              mem_state;
   logic [31:0]       q_w;

   // Widen q so case items are plain 32-bit constants regardless of N.
   assign q_w = 32'(q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         halt_pend_q <= 1'b0;
         stall_q     <= '0;
         ret_q       <= '0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
         stall_q     <= stall_d;
         ret_q       <= ret_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      stall_d     = '0;              // clears unless a stall cycle below
      ret_d       = ret_q;
      mem_state   = 1'b0;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      ar_from_pc  = 1'b0;
      ar_from_dr  = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      dr_load     = 1'b0;
      ir_load     = 1'b0;
      ac_add      = 1'b0;
      ac_and      = 1'b0;
      ac_inc      = 1'b0;
      mem_rd      = 1'b0;
      instr_done  = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            // Hold the sequencer at 0 so FETCH1 runs in the first RUN cycle.
            cnt_clr     = 1'b1;
            halt_pend_d = 1'b0;
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            halt_pend_d = halt_pend_q | halt_req;
            case (q_w)
               32'd0: begin
                  ar_from_pc = 1'b1;
                  cnt_inc    = 1'b1;
               end
               32'd1: begin
                  mem_state = 1'b1;
                  mem_rd    = 1'b1;
                  if (mem_ready) begin
                     dr_load = 1'b1;
                     pc_inc  = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end
               32'd2: begin
                  ir_load    = 1'b1;
                  ar_from_dr = 1'b1;
                  cnt_load   = 1'b1;
               end
               32'd3, 32'd5: begin
                  mem_state = 1'b1;
                  mem_rd    = 1'b1;
                  if (mem_ready) begin
                     dr_load = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end
               32'd4: begin
                  ac_add     = 1'b1;
                  cnt_clr    = 1'b1;
                  instr_done = 1'b1;
               end
               32'd6: begin
                  ac_and     = 1'b1;
                  cnt_clr    = 1'b1;
                  instr_done = 1'b1;
               end
               32'd7: begin
                  pc_load    = 1'b1;
                  cnt_clr    = 1'b1;
                  instr_done = 1'b1;
               end
               32'd8: begin
                  ac_inc     = 1'b1;
                  cnt_clr    = 1'b1;
                  instr_done = 1'b1;
               end
               default: begin
                  cnt_clr = 1'b1;
                  state_d = S_FAULT;
               end
            endcase

            // Stall: counter controls are already all zero, so q holds.
            if (mem_state && !mem_ready) begin
               stall_d = stall_q + 1'b1;
               if (stall_q == WAIT_W'(MEM_TIMEOUT - 1)) state_d = S_FAULT;
            end

            // halt_pend_d already folds in a same-cycle halt_req.
            if (instr_done) begin
               ret_d = ret_q + 1'b1;
               if (halt_pend_d) begin
                  state_d     = S_HALT;
                  halt_pend_d = 1'b0;
               end
            end
         end
         default: begin // S_FAULT: only reset leaves
            cnt_clr     = 1'b1;
            halt_pend_d = 1'b0;
         end
      endcase
   end

   assign running = (state_q == S_RUN);
   assign halted  = (state_q == S_HALT);
   assign fault   = (state_q == S_FAULT);
   assign retired = ret_q;

endmodule

// File: tb/tb_cu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cu_ctrl - directed bench for cu_ctrl with a behavioural sequencer model.
// The sequencer loads the execute entry point from a 2-bit opcode:
// 00 ADD->3, 01 AND->5, 10 JMP->7, 11 INC->8. q can be forced to test the
// illegal-state path.
// -----------------------------------------------------------------------------
module tb_cu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, halt_req, mem_ready;
   logic [3:0]  q, cnt = '0, force_v = '0;
   logic        force_en = 1'b0;
   logic [1:0]  opcode = 2'd0;
   logic        cnt_load, cnt_inc, cnt_clr;
   logic        ar_from_pc, ar_from_dr, pc_inc, pc_load, dr_load, ir_load;
   logic        ac_add, ac_and, ac_inc, mem_rd, instr_done;
   logic        running, halted, fault;
   logic [15:0] retired;
   logic [13:0] uops;
   logic [2:0]  status;
   int          n_run = 0, n_fail = 0;

   // Expected micro-op vectors, bit order matches uops below.
   localparam logic [13:0] E_CLR  = 14'b00_0000_0000_0001;
   localparam logic [13:0] E_F1   = 14'b10_0000_0000_0010;
   localparam logic [13:0] E_F2R  = 14'b00_1010_0001_0010;
   localparam logic [13:0] E_MRD  = 14'b00_0000_0001_0000;
   localparam logic [13:0] E_F3   = 14'b01_0001_0000_0100;
   localparam logic [13:0] E_X1R  = 14'b00_0010_0001_0010;
   localparam logic [13:0] E_ADD2 = 14'b00_0000_1000_1001;
   localparam logic [13:0] E_AND2 = 14'b00_0000_0100_1001;
   localparam logic [13:0] E_JMP1 = 14'b00_0100_0000_1001;
   localparam logic [13:0] E_INC1 = 14'b00_0000_0010_1001;

   always #5 clk = ~clk;

   assign q      = force_en ? force_v : cnt;
   assign uops   = {ar_from_pc, ar_from_dr, pc_inc, pc_load, dr_load, ir_load,
                    ac_add, ac_and, ac_inc, mem_rd, instr_done,
                    cnt_load, cnt_inc, cnt_clr};
   assign status = {running, halted, fault};

   always @(posedge clk) begin
      if (cnt_clr)       cnt <= '0;
      else if (cnt_load) cnt <= (opcode == 2'd0) ? 4'd3 : (opcode == 2'd1) ? 4'd5 :
                                (opcode == 2'd2) ? 4'd7 : 4'd8;
      else if (cnt_inc)  cnt <= cnt + 4'd1;
   end

   cu_ctrl #(.N(4), .MEM_TIMEOUT(15), .WAIT_W(4), .RET_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .q(q), .start(start), .halt_req(halt_req),
      .mem_ready(mem_ready), .cnt_load(cnt_load), .cnt_inc(cnt_inc),
      .cnt_clr(cnt_clr), .ar_from_pc(ar_from_pc), .ar_from_dr(ar_from_dr),
      .pc_inc(pc_inc), .pc_load(pc_load), .dr_load(dr_load), .ir_load(ir_load),
      .ac_add(ac_add), .ac_and(ac_and), .ac_inc(ac_inc), .mem_rd(mem_rd),
      .instr_done(instr_done), .running(running), .halted(halted),
      .fault(fault), .retired(retired)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock cycle: apply inputs just after the edge, check mid-cycle.
   task automatic cyc(input string tag, input logic st, input logic hr,
                      input logic mr, input logic [13:0] exp);
      @(posedge clk);
      #1;
      start = st; halt_req = hr; mem_ready = mr;
      #2;
      chk(tag, 32'(uops), 32'(exp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      chk("rst_uops", 32'(uops), 32'(E_CLR));
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
   endtask

   initial begin
      do_reset();

      // Start pulse, then ADD with zero wait.
      cyc("idle_start", 1, 0, 0, E_CLR);
      chk("idle_status", 32'(status), 32'd0);
      opcode = 2'd0;
      cyc("add_f1", 0, 0, 1, E_F1);
      chk("run_status", 32'(status), 32'b100);
      cyc("add_f2", 0, 0, 1, E_F2R);
      cyc("add_f3", 0, 0, 1, E_F3);
      cyc("add_x1", 0, 0, 1, E_X1R);
      cyc("add_x2", 0, 0, 1, E_ADD2);

      // INC then JMP back to back.
      opcode = 2'd3;
      cyc("inc_f1", 0, 0, 1, E_F1);
      chk("ret_after_add", 32'(retired), 32'd1);
      cyc("inc_f2", 0, 0, 1, E_F2R);
      cyc("inc_f3", 0, 0, 1, E_F3);
      cyc("inc_x1", 0, 0, 1, E_INC1);
      opcode = 2'd2;
      cyc("jmp_f1", 0, 0, 1, E_F1);
      chk("ret_after_inc", 32'(retired), 32'd2);
      cyc("jmp_f2", 0, 0, 1, E_F2R);
      cyc("jmp_f3", 0, 0, 1, E_F3);
      cyc("jmp_x1", 0, 0, 1, E_JMP1);

      // ADD with three FETCH2 stall cycles.
      opcode = 2'd0;
      cyc("st_f1", 0, 0, 1, E_F1);
      chk("ret_after_jmp", 32'(retired), 32'd3);
      for (int i = 0; i < 3; i++) begin
         cyc("st_f2_wait", 0, 0, 0, E_MRD);
         chk("st_f2_q", 32'(q), 32'd1);
      end
      cyc("st_f2", 0, 0, 1, E_F2R);
      cyc("st_f3", 0, 0, 1, E_F3);
      cyc("st_x1", 0, 0, 1, E_X1R);
      cyc("st_x2", 0, 0, 1, E_ADD2);

      // AND with halt_req pulsed in FETCH2.
      opcode = 2'd1;
      cyc("and_f1", 0, 0, 1, E_F1);
      cyc("and_f2", 0, 1, 1, E_F2R);
      cyc("and_f3", 0, 0, 1, E_F3);
      chk("and_still_run", 32'(status), 32'b100);
      cyc("and_x1", 0, 0, 1, E_X1R);
      cyc("and_x2", 0, 0, 1, E_AND2);
      cyc("halt_hold", 0, 1, 1, E_CLR);
      chk("halt_status", 32'(status), 32'b010);
      chk("halt_q", 32'(q), 32'd0);
      chk("halt_retired", 32'(retired), 32'd5);
      cyc("halt_start", 1, 0, 1, E_CLR);
      chk("halt_hr_ignored", 32'(status), 32'b010);

      // Resume; halt_req arriving in the done cycle itself.
      opcode = 2'd3;
      cyc("res_f1", 0, 0, 1, E_F1);
      chk("res_status", 32'(status), 32'b100);
      cyc("res_f2", 0, 0, 1, E_F2R);
      cyc("res_f3", 0, 0, 1, E_F3);
      cyc("res_x1", 0, 1, 1, E_INC1);
      cyc("res_halted", 0, 0, 1, E_CLR);
      chk("late_halt", 32'(status), 32'b010);
      chk("late_retired", 32'(retired), 32'd6);
      cyc("res2_start", 1, 0, 1, E_CLR);

      // Illegal q=12 in RUN.
      cyc("ill_f1", 0, 0, 1, E_F1);
      @(posedge clk);
      #1 force_en = 1'b1; force_v = 4'd12; start = 1'b0;
      #2 chk("ill_uops", 32'(uops), 32'(E_CLR));
      chk("ill_run", 32'(status), 32'b100);
      @(posedge clk);
      #1 force_en = 1'b0;
      #2 chk("ill_fault", 32'(status), 32'b001);
      chk("ill_retired", 32'(retired), 32'd6);
      cyc("ill_start", 1, 0, 1, E_CLR);
      chk("ill_stuck", 32'(status), 32'b001);

      // Timeout boundary: 14 stalls survive, 15 fault.
      do_reset();
      cyc("to_start", 1, 0, 0, E_CLR);
      opcode = 2'd0;
      cyc("to_f1", 0, 0, 1, E_F1);
      cyc("to_f2", 0, 0, 1, E_F2R);
      cyc("to_f3", 0, 0, 1, E_F3);
      for (int i = 0; i < 14; i++) cyc("to14_wait", 0, 0, 0, E_MRD);
      cyc("to14_x1", 0, 0, 1, E_X1R);
      chk("to14_run", 32'(status), 32'b100);
      cyc("to14_x2", 0, 0, 1, E_ADD2);
      cyc("to_f1b", 0, 0, 1, E_F1);
      cyc("to_f2b", 0, 0, 1, E_F2R);
      cyc("to_f3b", 0, 0, 1, E_F3);
      for (int i = 0; i < 15; i++) cyc("to15_wait", 0, 0, 0, E_MRD);
      chk("to15_last_run", 32'(status), 32'b100);
      cyc("to_fault", 0, 0, 1, E_CLR);
      chk("to_fault_status", 32'(status), 32'b001);
      chk("to_fault_ret", 32'(retired), 32'd1);
      cyc("to_start_ign", 1, 0, 1, E_CLR);
      chk("to_still_fault", 32'(status), 32'b001);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
